sm4_key_expand: RTL and testbench
=================================

Name: sm4_key_expand

Overview:
SM4 key-schedule engine that sits directly upstream of the key-path linear transform L'(x) = x ^ (x <<< 13) ^ (x <<< 23). It accepts a 128-bit master key MK and applies the FK whitening. It then iterates 32 rounds, one per accepted output, producing round keys rk0..rk31 in order:
- per round: tau (4 S-boxes) → L' → XOR.
- The round-key stream feeds the encrypt/decrypt round datapath.

Parameters:
ROUNDS, 32, number of round keys generated. Must be 32 for standard SM4; smaller values are permitted for debug only.
IDX_W, 5, width of rk_idx; must satisfy 2^IDX_W >= ROUNDS.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  reset; asynchronous and active-low.
mk  input  [0:127]  master key, bit 0 = MSB, big-endian word order MK0..MK3.
key_valid  input  1  mk is valid.
key_ready  output  1  engine idle, can accept mk.
rk_data  output  [0:31]  current round key rk_i.
rk_idx  output  IDX_W  round index i of rk_data.
rk_valid  output  1  rk_data/rk_idx valid.
rk_ready  input  1  consumer accepts rk_data this cycle.
done  output  1  one-cycle pulse after the final rk is accepted.

Behaviour:
- Reset (async assert, sync deassert in clock domain): state=IDLE, K window regs=0, cnt=0, rk_valid=0, key_ready=1 (after reset deassert), done=0, rk_data=0, rk_idx=0.
- Constants:
  - FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - CK_i byte j = ((4i+j)*7) mod 256, j=0 MSB; e.g. CK0=00070E15, CK1=1C232A31, CK31=646B7279.
- FSM IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: K0..K3 <= MK0^FK0..MK3^FK3; cnt <= 0; go RUN.
- FSM RUN:
  - key_ready=0; rk_valid=1.
  - rk_data = K0 ^ L'(tau(K1^K2^K3^CK_cnt)), computed combinationally from registered state, so it is stable while stalled.
  - rk_idx = cnt.
  - On rk_valid&&rk_ready: K0..K3 <= K1,K2,K3,rk_data; cnt <= cnt+1.
  - If cnt==ROUNDS-1 on that handshake: go IDLE and assert done for exactly 1 cycle (the cycle after the handshake).
- Latency: rk0 is valid the cycle after mk acceptance. With rk_ready held high, rk_i appears at cycle i+1 and done is high at cycle ROUNDS+1.
- Backpressure: rk_ready low holds state, rk_data, rk_idx and rk_valid unchanged indefinitely.
- key_valid while RUN: ignored (key_ready=0); mk is not sampled.
- IDLE → RUN in the same cycle done pulses: allowed. key_ready is already 1 in the done cycle, so back-to-back keys lose no cycles.
- cnt wrap: cnt never exceeds ROUNDS-1; no wrap is possible.
- Reset mid-RUN: all state is lost immediately; rk_valid drops asynchronously; no done is produced.
- tau: four parallel lookups in the standard SM4 S-box on bytes [0:7], [8:15], [16:23], [24:31].

Decomposition:
- Package sm4_pkg:
  - FK0..FK3 constants.
  - SBOX 256x8 table.
  - ck_func(i) returning CK_i.
  - typedef word_t [0:31].
- Sub-module sm4_tau: 32→32 combinational, 4 S-box instances.
- The existing key-path L' transform block is instantiated as-is.
- The FSM, the K shift window and the counter stay in the top module.

Test Plan:
1. mk=0123456789ABCDEFFEDCBA9876543210, rk_ready=1 → rk0=F12186F9, rk1=41662B61, rk2=5A6AB19A, rk3=7BA92077, rk31=9124A012. done pulses at cycle 33 after acceptance.
2. Same key with rk_ready randomly low ~50% → identical rk sequence. rk_data/rk_idx are stable during every stall; exactly 32 handshakes.
3. Assert key_valid with a different mk during RUN → ignored; the sequence still matches scenario 1.
4. Two keys back-to-back (second key_valid held) → second key accepted in the done cycle. Its rk0 is valid the next cycle. No gap beyond 1 cycle.
5. rst_n low at rk_idx=10 → rk_valid=0 immediately. After release key_ready=1, done never asserts, and a fresh run reproduces scenario 1.
6. mk=all-zero → rk0 equals K0 ^ L'(tau(K1^K2^K3^00070E15)) computed with FK-only K values. Compare all 32 rks against the C reference model.

Source files
------------

// File: rtl/sm4_pkg.sv
// SM4 key-schedule shared definitions: word type, FSM states, FK whitening
// constants, the standard S-box and the CK round-constant generator.
package sm4_pkg;

    typedef logic [0:31] word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam word_t FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // Byte j of CK_i is (4i+j)*7 mod 256; byte 0 sits in bits [0:7] (MSB).
    function automatic word_t ck_func(input int unsigned i);
        word_t ck;
        for (int j = 0; j < 4; j++) begin
            ck[8*j +: 8] = 8'((4 * i + 32'(j)) * 7);
        end
        return ck;
    endfunction

endpackage

// File: rtl/sm4_key_expand_if.sv
// Key-in / round-key-out handshake bundle of the SM4 key-schedule engine.
interface sm4_key_expand_if
    import sm4_pkg::*;
#(
    parameter int IDX_W = 5
);
    logic [0:127]     mk;
    logic             key_valid;
    logic             key_ready;
    word_t            rk_data;
    logic [IDX_W-1:0] rk_idx;
    logic             rk_valid;
    logic             rk_ready;
    logic             done;

    modport master (
        output mk, key_valid, rk_ready,
        input  key_ready, rk_data, rk_idx, rk_valid, done
    );

    modport slave (
        input  mk, key_valid, rk_ready,
        output key_ready, rk_data, rk_idx, rk_valid, done
    );
endinterface

// File: rtl/sm4_lprime.sv
// Key-path linear transform L'(x) = x ^ (x <<< 13) ^ (x <<< 23); bit 0 is the MSB.
module sm4_lprime
    import sm4_pkg::*;
(
    input  word_t x,
    output word_t y
);
    assign y = x ^ {x[13:31], x[0:12]} ^ {x[23:31], x[0:22]};
endmodule

// File: rtl/sm4_tau.sv
// SM4 non-linear substitution tau: four parallel S-box lookups, one per byte.
module sm4_tau
    import sm4_pkg::*;
(
    input  word_t a,
    output word_t b
);
    for (genvar j = 0; j < 4; j++) begin : g_sbox
        assign b[8*j +: 8] = SBOX[a[8*j +: 8]];
    end
endmodule

// File: rtl/sm4_key_expand.sv
// SM4 key schedule: FK whitening of MK, then one round key per accepted
// output handshake, rk0..rk(ROUNDS-1), with a one-cycle done pulse at the end.
module sm4_key_expand
    import sm4_pkg::*;
#(
    parameter int ROUNDS = 32,
    parameter int IDX_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    sm4_key_expand_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t           state_q, state_d;
    word_t            k_q [4];
    word_t            k_d [4];
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    word_t tau_in;
    word_t tau_out;
    word_t lp_out;
    word_t rk_word;

    // Round key is purely combinational from the window, so it holds during stalls.
    assign tau_in  = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_func(32'(cnt_q));

    sm4_tau    u_tau    (.a(tau_in),  .b(tau_out));
    sm4_lprime u_lprime (.x(tau_out), .y(lp_out));

    assign rk_word = k_q[0] ^ lp_out;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.key_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        k_d[i] = bus.mk[32*i +: 32] ^ FK[i];
                    end
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.rk_ready) begin
                    k_d[0] = k_q[1];
                    k_d[1] = k_q[2];
                    k_d[2] = k_q[3];
                    k_d[3] = rk_word;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '{default: '0};
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs are forced to zero outside RUN so idle/reset values are clean.
    assign bus.key_ready = (state_q == ST_IDLE);
    assign bus.rk_valid  = (state_q == ST_RUN);
    assign bus.rk_data   = (state_q == ST_RUN) ? rk_word : '0;
    assign bus.rk_idx    = (state_q == ST_RUN) ? cnt_q : '0;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Self-checking bench for sm4_key_expand: a transaction-level key-schedule
// model checked every cycle, plus directed scenarios with literal round keys.
module tb_sm4_key_expand;
    localparam int ROUNDS = 32;
    localparam int IDX_W  = 5;
    localparam logic [127:0] KEY1 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KEY2 = 128'h00112233445566778899AABBCCDDEEFF;

    typedef logic [31:0] w_t;

    localparam logic [7:0] SB [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm4_key_expand_if #(.IDX_W(IDX_W)) bus ();

    sm4_key_expand #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    w_t cap [ROUNDS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference key schedule written straight from the algorithm.
    function automatic w_t rotl(input w_t x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic w_t tsub(input w_t x);
        w_t r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = SB[x[8*j +: 8]];
        return r;
    endfunction

    function automatic w_t rk_at(input logic [127:0] key, input int idx);
        w_t fk [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
        w_t k [4];
        w_t t, ck, nk;
        for (int i = 0; i < 4; i++) k[i] = key[127-32*i -: 32] ^ fk[i];
        nk = '0;
        for (int i = 0; i <= idx; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4 * i + j) * 7);
            t  = tsub(k[1] ^ k[2] ^ k[3] ^ ck);
            nk = k[0] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
            k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = nk;
        end
        return nk;
    endfunction

    // Transaction-level model: which key is being expanded and how far.
    logic         m_run  = 1'b0;
    logic         m_done = 1'b0;
    int           m_idx  = 0;
    logic [127:0] m_key  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_idx  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_run) begin
                if (bus.key_valid) begin
                    m_key <= bus.mk;
                    m_run <= 1'b1;
                    m_idx <= 0;
                end
            end else if (bus.rk_ready) begin
                if (m_idx == ROUNDS - 1) begin
                    m_run  <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mon_rk_valid", 32'(bus.rk_valid), 32'(m_run));
            chk("mon_done", 32'(bus.done), 32'(m_done));
            if (rst_n) chk("mon_key_ready", 32'(bus.key_ready), 32'(!m_run));
            if (m_run) begin
                chk("mon_rk_idx", 32'(bus.rk_idx), 32'(m_idx));
                chk("mon_rk_data", bus.rk_data, rk_at(m_key, m_idx));
            end else begin
                chk("mon_rk_data_idle", bus.rk_data, 32'h0);
            end
        end
    end

    task automatic wait_done(input int stall_pct, input int poke_cycles,
                             output int done_cyc, output int hs, output bit first_vld);
        int cyc;
        cyc = 0; done_cyc = -1; hs = 0; first_vld = 1'b0;
        while (done_cyc < 0 && cyc < 1000) begin
            cyc++;
            if (poke_cycles > 0) begin
                bus.key_valid = (cyc <= poke_cycles);
                bus.mk        = ~KEY1;
            end
            bus.rk_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (cyc == 1) first_vld = bus.rk_valid;
            if (bus.rk_valid && bus.rk_ready) begin
                hs++;
                cap[bus.rk_idx] = bus.rk_data;
            end
            if (bus.done) done_cyc = cyc;
            @(posedge clk); #1;
        end
        chk("done_within_budget", 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic run_key(input logic [127:0] key, input int stall_pct, input int poke_cycles,
                           output int done_cyc, output int hs);
        bit fv;
        bus.mk        = key;
        bus.key_valid = 1'b1;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        wait_done(stall_pct, poke_cycles, done_cyc, hs, fv);
        chk("rk0_next_cycle", 32'(fv), 32'd1);
    endtask

    task automatic check_known(input string tag);
        chk({tag, "_rk0"},  cap[0],  32'hF12186F9);
        chk({tag, "_rk1"},  cap[1],  32'h41662B61);
        chk({tag, "_rk2"},  cap[2],  32'h5A6AB19A);
        chk({tag, "_rk3"},  cap[3],  32'h7BA92077);
        chk({tag, "_rk31"}, cap[31], 32'h9124A012);
    endtask

    initial begin
        int dc, hs, guard, dn;
        bit fv;
        bus.mk        = '0;
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b0;

        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_key_ready", 32'(bus.key_ready), 32'd1);
        chk("reset_rk_valid", 32'(bus.rk_valid), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_rk_data", bus.rk_data, 32'h0);
        chk("reset_rk_idx", 32'(bus.rk_idx), 32'd0);

        // Pin the model against the published vectors.
        chk("model_rk0", rk_at(KEY1, 0), 32'hF12186F9);
        chk("model_rk1", rk_at(KEY1, 1), 32'h41662B61);
        chk("model_rk31", rk_at(KEY1, 31), 32'h9124A012);
        @(posedge clk); #1;

        // Scenario 1: free-running consumer.
        run_key(KEY1, 0, 0, dc, hs);
        chk("s1_done_cycle", dc, 33);
        chk("s1_handshakes", hs, 32);
        check_known("s1");

        // Scenario 2: random backpressure.
        run_key(KEY1, 50, 0, dc, hs);
        chk("s2_handshakes", hs, 32);
        check_known("s2");

        // Scenario 3: competing key_valid during RUN.
        run_key(KEY1, 0, 10, dc, hs);
        chk("s3_done_cycle", dc, 33);
        check_known("s3");

        // Scenario 4: back-to-back keys with key_valid held.
        bus.mk        = KEY1;
        bus.key_valid = 1'b1;
        @(posedge clk); #1;
        bus.mk = KEY2;
        wait_done(0, 0, dc, hs, fv);
        bus.key_valid = 1'b0;
        chk("s4_first_done", dc, 33);
        check_known("s4");
        wait_done(0, 0, dc, hs, fv);
        chk("s4_no_gap", 32'(fv), 32'd1);
        chk("s4_second_done", dc, 33);
        chk("s4_second_hs", hs, 32);
        chk("s4_second_rk0", cap[0], rk_at(KEY2, 0));

        // Scenario 5: reset mid-run at rk_idx 10.
        bus.mk        = KEY1;
        bus.key_valid = 1'b1;
        bus.rk_ready  = 1'b1;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (bus.rk_idx != 5'd10 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("s5_reach_idx10", 32'(bus.rk_idx), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rk_valid_async", 32'(bus.rk_valid), 32'd0);
        chk("s5_done_low", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("s5_key_ready", 32'(bus.key_ready), 32'd1);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("s5_no_done", dn, 0);
        @(posedge clk); #1;
        run_key(KEY1, 0, 0, dc, hs);
        chk("s5_rerun_done", dc, 33);
        check_known("s5");

        // Scenario 6: all-zero key, every rk checked by the model.
        run_key(128'h0, 0, 0, dc, hs);
        chk("s6_handshakes", hs, 32);
        chk("s6_rk0", cap[0], rk_at(128'h0, 0));
        chk("s6_rk31", cap[31], rk_at(128'h0, 31));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
